// File: rtl/hazard_stall_controller.sv
// Hazard, forwarding and stall sequencer for the 5-stage pipeline: load-use stalls, branch flush,
// operand-forwarding select and a freeze while a multi-cycle data-memory access completes.
module hazard_stall_controller #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  ID_Rn,
    input  logic [3:0]  ID_Rm,
    input  logic [3:0]  ID_Rc,
    input  logic        ID_UseA,
    input  logic        ID_UseB,
    input  logic        ID_UseC,
    input  logic        ID_Branch_Taken,
    input  logic [3:0]  EX_Rd,
    input  logic        EX_rf,
    input  logic        EX_Load,
    input  logic        EX_MemEnable,
    input  logic [3:0]  MEM_Rd,
    input  logic        MEM_rf,
    input  logic [3:0]  WB_Rd,
    input  logic        WB_rf,
    output logic        PC_LE,
    output logic        IFID_LE,
    output logic        IDEX_LE,
    output logic        EXMEM_LE,
    output logic        IFID_CLR,
    output logic        IDEX_Bubble,
    output logic        MEMWB_Bubble,
    output logic [1:0]  Fwd_A,
    output logic [1:0]  Fwd_B,
    output logic [1:0]  Fwd_C,
    output logic [15:0] Stall_Cycles
);

    localparam logic [0:0]       StRun     = 1'b0;
    localparam logic [0:0]       StMemWait = 1'b1;
    localparam logic [3:0]       RegPc     = 4'hF;
    localparam logic [1:0]       FwdRf     = 2'b00;
    localparam logic [1:0]       FwdEx     = 2'b01;
    localparam logic [1:0]       FwdMem    = 2'b10;
    localparam logic [1:0]       FwdWb     = 2'b11;
    localparam logic [CNT_W-1:0] CntLoad   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam bit               FreezeEn  = (MEM_LATENCY > 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q, stall_d;

    logic             hit_a, hit_b, hit_c;
    logic             load_use;
    logic [1:0]       fwd_a, fwd_b, fwd_c;

    // Youngest producer wins; the PC is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       use_src,
        input logic [3:0] rs,
        input logic [3:0] ex_rd,
        input logic       ex_rf,
        input logic [3:0] mem_rd,
        input logic       mem_rf,
        input logic [3:0] wb_rd,
        input logic       wb_rf
    );
        logic [1:0] sel;
        sel = FwdRf;
        if (use_src && rs != RegPc) begin
            if (ex_rf && ex_rd == rs) begin
                sel = FwdEx;
            end else if (mem_rf && mem_rd == rs) begin
                sel = FwdMem;
            end else if (wb_rf && wb_rd == rs) begin
                sel = FwdWb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ID_UseA, ID_Rn, EX_Rd, EX_rf, MEM_Rd, MEM_rf, WB_Rd, WB_rf);
        fwd_b = fwd_sel(ID_UseB, ID_Rm, EX_Rd, EX_rf, MEM_Rd, MEM_rf, WB_Rd, WB_rf);
        fwd_c = fwd_sel(ID_UseC, ID_Rc, EX_Rd, EX_rf, MEM_Rd, MEM_rf, WB_Rd, WB_rf);
    end

    always_comb begin
        hit_a    = ID_UseA && (ID_Rn == EX_Rd);
        hit_b    = ID_UseB && (ID_Rm == EX_Rd);
        hit_c    = ID_UseC && (ID_Rc == EX_Rd);
        load_use = EX_Load && EX_rf && (EX_Rd != RegPc) && (hit_a || hit_b || hit_c);
    end

    // Stage control: reset, then memory freeze, then load-use stall, then branch flush.
    always_comb begin
        PC_LE        = 1'b1;
        IFID_LE      = 1'b1;
        IDEX_LE      = 1'b1;
        EXMEM_LE     = 1'b1;
        IFID_CLR     = 1'b0;
        IDEX_Bubble  = 1'b0;
        MEMWB_Bubble = 1'b0;
        if (!CLR) begin
            PC_LE        = 1'b0;
            IFID_LE      = 1'b0;
            IDEX_LE      = 1'b0;
            EXMEM_LE     = 1'b0;
            IFID_CLR     = 1'b1;
            IDEX_Bubble  = 1'b1;
            MEMWB_Bubble = 1'b1;
        end else if (state_q == StMemWait) begin
            PC_LE        = 1'b0;
            IFID_LE      = 1'b0;
            IDEX_LE      = 1'b0;
            EXMEM_LE     = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (load_use) begin
            // Branch in ID is held with its instruction and re-resolved next cycle.
            PC_LE       = 1'b0;
            IFID_LE     = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (ID_Branch_Taken) begin
            IFID_CLR = 1'b1;
        end
    end

    always_comb begin
        Fwd_A        = CLR ? fwd_a : FwdRf;
        Fwd_B        = CLR ? fwd_b : FwdRf;
        Fwd_C        = CLR ? fwd_c : FwdRf;
        Stall_Cycles = CLR ? stall_q : 16'h0000;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        if (!PC_LE && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        case (state_q)
            StRun: begin
                if (FreezeEn && EX_MemEnable) begin
                    state_d = StMemWait;
                    cnt_d   = CntLoad;
                end
            end
            StMemWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StRun;
            cnt_q   <= '0;
            stall_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule
